// File: rtl/platform_scheduler.sv
// Per-frame platform table controller: picks the scroll from the doodle height,
// walks the table one slot per clock, respawns fallen platforms and counts them.
module platform_scheduler #(
    parameter int NUM_PLAT    = 8,
    parameter int SCREEN_H    = 480,
    parameter int SCROLL_LINE = 160,
    parameter int MAX_SCROLL  = 15,
    parameter int INIT_X      = 240,
    parameter int INIT_GAP    = 60,
    localparam int IDX_W      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic [9:0]       doodle_Y,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [9:0]       rd_X,
    output logic [9:0]       rd_Y,
    output logic [3:0]       scroll_amt,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      score,
    output logic             overrun
);

    localparam logic [10:0]      SCREEN_H_W    = 11'(SCREEN_H);
    localparam logic [10:0]      SCROLL_LINE_W = 11'(SCROLL_LINE);
    localparam logic [10:0]      MAX_SCROLL_W  = 11'(MAX_SCROLL);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_PLAT - 1);
    localparam logic [9:0]       LFSR_SEED     = 10'h2A5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [3:0]       scroll_amt_reg;
    logic [9:0]       doodle_y_reg;
    logic [9:0]       lfsr_reg;
    logic [15:0]      score_reg;
    logic             overrun_reg;
    logic [9:0]       rd_x_reg, rd_y_reg;

    logic [9:0]       x_reg [NUM_PLAT];
    logic [9:0]       y_reg [NUM_PLAT];

    // Scroll decision: distance above the scroll line, computed in 11 bits, then capped
    logic [10:0] doodle_y_ext;
    logic [10:0] scroll_diff;
    logic [3:0]  scroll_calc;

    assign doodle_y_ext = {1'b0, doodle_y_reg};
    assign scroll_diff  = SCROLL_LINE_W - doodle_y_ext;

    always_comb begin
        scroll_calc = '0;
        if (doodle_y_ext < SCROLL_LINE_W) begin
            if (scroll_diff > MAX_SCROLL_W)
                scroll_calc = 4'(MAX_SCROLL);
            else
                scroll_calc = scroll_diff[3:0];
        end
    end

    // Table walk datapath for the slot currently addressed by idx_reg
    logic        upd_en;
    logic [9:0]  cur_y;
    logic [10:0] sum_y;
    logic        fell_off;
    logic        respawn;
    logic [9:0]  wr_y;
    logic [9:0]  wr_x;

    assign upd_en   = (state_reg == S_UPDATE);
    assign cur_y    = y_reg[idx_reg];
    assign sum_y    = {1'b0, cur_y} + {7'd0, scroll_amt_reg};
    assign fell_off = (sum_y >= SCREEN_H_W);
    assign respawn  = upd_en && fell_off;
    assign wr_y     = fell_off ? 10'(sum_y - SCREEN_H_W) : sum_y[9:0];
    assign wr_x     = {1'b0, lfsr_reg[8:0]};

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (frame_start)
                    state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                idx_next = '0;
                if (scroll_calc == 4'd0)
                    state_next = S_DONE;
                else
                    state_next = S_UPDATE;
            end
            S_UPDATE: begin
                if (idx_reg == LAST_IDX)
                    state_next = S_DONE;
                else
                    idx_next = idx_reg + 1'b1;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            scroll_amt_reg <= '0;
            doodle_y_reg   <= '0;
            lfsr_reg       <= LFSR_SEED;
            score_reg      <= '0;
            overrun_reg    <= 1'b0;
            rd_x_reg       <= '0;
            rd_y_reg       <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            lfsr_reg  <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
            // Read samples the table before this edge's write lands
            rd_x_reg  <= x_reg[rd_idx];
            rd_y_reg  <= y_reg[rd_idx];
            if (state_reg == S_IDLE && frame_start)
                doodle_y_reg <= doodle_Y;
            if (state_reg == S_CAPTURE)
                scroll_amt_reg <= scroll_calc;
            if (respawn && score_reg != 16'hFFFF)
                score_reg <= score_reg + 16'd1;
            if (frame_start && state_reg != S_IDLE)
                overrun_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_plat
            localparam int INIT_Y = SCREEN_H - 10 - gi * INIT_GAP;

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    x_reg[gi] <= 10'(INIT_X);
                    y_reg[gi] <= 10'(INIT_Y);
                end else if (upd_en && idx_reg == IDX_W'(gi)) begin
                    y_reg[gi] <= wr_y;
                    if (fell_off)
                        x_reg[gi] <= wr_x;
                end
            end
        end
    endgenerate

    assign rd_X       = rd_x_reg;
    assign rd_Y       = rd_y_reg;
    assign scroll_amt = scroll_amt_reg;
    assign busy       = (state_reg != S_IDLE);
    assign frame_done = (state_reg == S_DONE);
    assign score      = score_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler: reset layout, scroll/no-scroll frames,
// respawn X from an LFSR reference, overrun handling and reset mid-walk.
module tb_platform_scheduler;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  doodle_y = '0;
    logic [2:0]  rd_idx = '0;
    logic [9:0]  rd_x, rd_y;
    logic [3:0]  scroll_amt;
    logic        busy, frame_done, overrun;
    logic [15:0] score;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [9:0]  lfsr_m;
    logic [9:0]  x_m [NP];
    logic [9:0]  y_m [NP];
    logic [15:0] score_m;
    logic        ovr_m;

    platform_scheduler dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .frame_start(frame_start),
        .doodle_Y   (doodle_y),
        .rd_idx     (rd_idx),
        .rd_X       (rd_x),
        .rd_Y       (rd_y),
        .scroll_amt (scroll_amt),
        .busy       (busy),
        .frame_done (frame_done),
        .score      (score),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference LFSR, x^10+x^7+1, free-running out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_m <= 10'h2A5;
        else
            lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NP; i++) begin
            x_m[i] = 10'd240;
            y_m[i] = 10'(470 - 60 * i);
        end
        score_m = '0;
        ovr_m   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic read_entry(input int i, output logic [9:0] rx, output logic [9:0] ry);
        @(negedge clk);
        rd_idx = 3'(i);
        @(negedge clk);
        rx = rd_x;
        ry = rd_y;
    endtask

    task automatic verify_table(input string tag);
        logic [9:0] rx, ry;
        for (int i = 0; i < NP; i++) begin
            read_entry(i, rx, ry);
            check($sformatf("%s_x%0d", tag, i), 32'(rx), 32'(x_m[i]));
            check($sformatf("%s_y%0d", tag, i), 32'(ry), 32'(y_m[i]));
        end
        check($sformatf("%s_score", tag), 32'(score), 32'(score_m));
    endtask

    // One frame: frame_start in cycle 0, optional second pulse in cycle dup_at
    task automatic run_frame(input logic [9:0] dy, input int exp_scroll, input int dup_at);
        int          done_cyc;
        logic [9:0]  rec [NP];
        logic [10:0] ny;
        logic [9:0]  exp_y0;
        done_cyc = (exp_scroll > 0) ? NP + 2 : 2;
        ny = {1'b0, y_m[0]} + 11'(exp_scroll);
        exp_y0 = (ny >= 11'd480) ? 10'(ny - 11'd480) : ny[9:0];
        for (int j = 0; j < NP; j++) rec[j] = '0;

        @(negedge clk);
        frame_start = 1'b1;
        doodle_y    = dy;
        rd_idx      = '0;
        @(negedge clk);
        frame_start = 1'b0;
        doodle_y    = 10'd999;
        check($sformatf("f%0d_busy_c1", dy), 32'(busy), 32'd1);
        check($sformatf("f%0d_done_c1", dy), 32'(frame_done), 32'd0);
        for (int c = 2; c <= done_cyc; c++) begin
            @(negedge clk);
            frame_start = (c == dup_at);
            if (c - 2 < NP) rec[c-2] = lfsr_m;
            check($sformatf("f%0d_done_c%0d", dy, c), 32'(frame_done), 32'(c == done_cyc));
            if (exp_scroll > 0 && c == 3)
                check($sformatf("f%0d_rd_old", dy), 32'(rd_y), 32'(y_m[0]));
            if (exp_scroll > 0 && c == 4)
                check($sformatf("f%0d_rd_new", dy), 32'(rd_y), 32'(exp_y0));
        end
        check($sformatf("f%0d_scroll", dy), 32'(scroll_amt), 32'(exp_scroll));
        if (dup_at > 0) ovr_m = 1'b1;
        repeat (3) begin
            @(negedge clk);
            frame_start = 1'b0;
            check($sformatf("f%0d_idle_busy", dy), 32'(busy), 32'd0);
            check($sformatf("f%0d_idle_done", dy), 32'(frame_done), 32'd0);
        end
        check($sformatf("f%0d_overrun", dy), 32'(overrun), 32'(ovr_m));

        if (exp_scroll > 0) begin
            for (int j = 0; j < NP; j++) begin
                ny = {1'b0, y_m[j]} + 11'(exp_scroll);
                if (ny >= 11'd480) begin
                    y_m[j] = 10'(ny - 11'd480);
                    x_m[j] = {1'b0, rec[j][8:0]};
                    if (score_m != 16'hFFFF) score_m = score_m + 16'd1;
                end else begin
                    y_m[j] = ny[9:0];
                end
            end
        end
        verify_table($sformatf("f%0d", dy));
    endtask

    initial begin
        logic [9:0] rx, ry;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_scroll", 32'(scroll_amt), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rdx", 32'(rd_x), 32'd0);
        check("rst_rdy", 32'(rd_y), 32'd0);
        rst_n = 1'b1;
        reset_model();
        verify_table("reset");

        run_frame(10'd300, 0, 0);

        run_frame(10'd150, 10, 0);
        read_entry(0, rx, ry);
        check("s10_y0_wrap", 32'(ry), 32'd0);
        read_entry(1, rx, ry);
        check("s10_y1", 32'(ry), 32'd420);
        read_entry(7, rx, ry);
        check("s10_y7", 32'(ry), 32'd60);
        check("s10_score", 32'(score), 32'd1);

        do_reset();
        run_frame(10'd0, 15, 0);
        read_entry(0, rx, ry);
        check("s15a_y0", 32'(ry), 32'd5);
        run_frame(10'd0, 15, 0);
        read_entry(0, rx, ry);
        check("s15b_y0", 32'(ry), 32'd20);
        run_frame(10'd0, 15, 0);
        read_entry(0, rx, ry);
        check("s15c_y0", 32'(ry), 32'd35);
        check("s15_score", 32'(score), 32'd1);

        run_frame(10'd160, 0, 0);
        run_frame(10'd159, 1, 0);
        run_frame(10'd145, 15, 0);
        run_frame(10'd146, 14, 0);

        run_frame(10'd150, 10, 4);

        // Reset while the walk is at slot 3
        @(negedge clk);
        frame_start = 1'b1;
        doodle_y    = 10'd0;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        check("abort_scroll", 32'(scroll_amt), 32'd0);
        check("abort_score", 32'(score), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_rdx", 32'(rd_x), 32'd0);
        check("abort_rdy", 32'(rd_y), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        verify_table("abort");
        check("abort_overrun_after", 32'(overrun), 32'd0);

        run_frame(10'd300, 0, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/platform_scheduler.md
Name: platform_scheduler

Overview:
- Per-frame controller for the platform layer: owns the table of NUM_PLAT platform positions that the colour mapper draws.
- At each frame start it decides the screen scroll from the doodle's height and walks the table one entry per clock. It shifts platforms down and respawns any that fall off the bottom at the top, with a pseudo-random X.
- It exports a registered read port for the colour mapper, the scroll amount for the doodle motion block, and a score counter.

Parameters:
- NUM_PLAT, 8, number of platform slots (power of two, max 16)
- SCREEN_H, 480, visible lines; Y wrap modulus
- SCROLL_LINE, 160, doodle Y above which the screen scrolls
- MAX_SCROLL, 15, per-frame scroll cap in lines
- INIT_X, 240, reset X of every platform
- INIT_GAP, 60, reset vertical spacing between platforms

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- doodle_Y  in  10  doodle top Y, sampled on frame_start
- rd_idx  in  log2(NUM_PLAT)  platform index to read
- rd_X  out  10  X of platform rd_idx, 1-cycle latency
- rd_Y  out  10  Y of platform rd_idx, 1-cycle latency
- scroll_amt  out  4  scroll applied this frame; held until next CAPTURE
- busy  out  1  high in CAPTURE/UPDATE/DONE
- frame_done  out  1  one-cycle pulse when table update completes
- score  out  16  respawn count, saturating
- overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (async assert, sync release) sets:
  - FSM=IDLE; busy=0; frame_done=0; scroll_amt=0; score=0; overrun=0; rd_X=0; rd_Y=0.
  - Platform i: X=INIT_X, Y=SCREEN_H-10-i*INIT_GAP. With defaults Y = 470,410,350,290,230,170,110,50.
  - LFSR=10'h2A5.
- Reset mid-UPDATE aborts the walk and restores the reset layout; no partial state survives.
- LFSR: 10-bit Fibonacci, taps bits 9 and 6 (x^10+x^7+1). Shifts every clock out of reset; never reaches all-zero.
- FSM:
  - IDLE: on frame_start -> CAPTURE.
  - CAPTURE (1 cycle):
    - If doodle_Y < SCROLL_LINE: scroll = min(SCROLL_LINE-doodle_Y, MAX_SCROLL); else scroll = 0.
    - Register scroll into scroll_amt.
    - scroll==0 -> DONE; else idx=0 -> UPDATE.
  - UPDATE (one entry per cycle, NUM_PLAT cycles):
    - Compute newY = Y[idx]+scroll_amt in 11 bits.
    - If newY < SCREEN_H: Y[idx]=newY.
    - Else (respawn): Y[idx]=newY-SCREEN_H; X[idx]=LFSR[8:0] zero-extended (0..511, always fits 640-wide screen with 80-px platform); score+=1, saturating at 16'hFFFF.
    - idx==NUM_PLAT-1 -> DONE; else idx+1.
  - DONE (1 cycle): frame_done=1 -> IDLE.
- Latency from frame_start to frame_done:
  - scroll>0: NUM_PLAT+2 cycles (10 with defaults).
  - scroll==0: 2 cycles.
- frame_start while busy is ignored, and overrun is set to 1; only reset clears it.
- frame_start in the same cycle as the DONE->IDLE transition is also ignored and sets overrun.
- Read port:
  - rd_X/rd_Y register the table entry at rd_idx on each clock: value read = table content before that edge's write.
  - Reading the entry being written in the same cycle returns the old value.
- Width rules:
  - SCROLL_LINE-doodle_Y is computed in 11 bits, then clamped.
  - Y stays in [0, SCREEN_H-1] at all times.

Test Plan:
- Reset with Reset=0 for 3 cycles, release, read idx 0..7 -> X=240 all; Y=470,410,350,290,230,170,110,50; score=0; busy=0.
- doodle_Y=300 on frame_start -> scroll_amt=0, frame_done 2 cycles later, table unchanged, score=0.
- doodle_Y=150 -> scroll_amt=10, frame_done at +10 cycles. Idx0 Y=470+10=480 wraps to 0 with new X=LFSR[8:0] and score=1; idx1 Y=420; idx7 Y=60.
- doodle_Y=0 -> scroll_amt=15 (clamped); three consecutive frames -> idx0 Y goes 470,485→5,20,35 (wraps on first); score increments exactly once per wrap.
- Second frame_start 4 cycles after first -> ignored, overrun=1 sticks, first frame completes normally, frame_done pulses once.
- Assert Reset at UPDATE idx=3 -> immediately all outputs at reset values, table equals reset layout, overrun=0.
